passcode_checker: RTL and testbench
===================================

# passcode_checker

Passcode storage, comparison and lockout timer for the lock controller. It consumes the controller FSM's `input_value`, `store_value` and `compare` levels, and captures keypad digits from `digit_in`. It drives back `correct_password`, `invalid_password` and `end_sleep`. It holds the stored code, the attempt-entry buffer and the sleep countdown.

## Interface
- `DIGIT_W`, 4: bits per digit.
- `CODE_LEN`, 4: digits per code, 1..8.
- `DEFAULT_CODE`, 16'h1234: stored code after reset, `CODE_LEN*DIGIT_W` bits, first digit in MSBs.
- `SLEEP_CYCLES`, 8: lockout length in clk cycles, ≥4.
- `MASTER_CODE`, 16'h0000: override code, used only with `PASSCODE_MASTER_CODE_EN`.

Ports:
- `clk`  in  1  clock.
- `system_reset`  in  1  reset, asynchronous, active-high.
- `digit_in`  in  DIGIT_W  keypad digit, sampled on a capture edge.
- `input_value`  in  1  FSM level: attempt digit capture.
- `store_value`  in  1  FSM level: new-code digit capture.
- `compare`  in  1  FSM level: evaluate attempt.
- `correct_password`  out  1  held result, attempt matched.
- `invalid_password`  out  1  held result, attempt rejected.
- `end_sleep`  out  1  held, lockout expired.

## Operation
- Edge detect:
  - Registered copies of `input_value`, `store_value` and `compare` are kept (reset 0).
  - An event is level=1 with prev=0, acted on at that clk edge.
  - Held levels never re-trigger.
- Event priority in one cycle: compare > input > store. Lower-priority events that cycle are dropped.
- Input event:
  - `digit_in` shifts into the entry buffer LSB-side.
  - `entry_cnt` increments, saturating at CODE_LEN.
  - A digit arriving at `entry_cnt`==CODE_LEN sets the `overrun` flag. The buffer keeps the last CODE_LEN digits.
  - Clears both result outputs and `end_sleep`, and stops the timer.
- Store event:
  - `digit_in` shifts into the staging buffer and `stage_cnt` increments.
  - When `stage_cnt` reaches CODE_LEN, the staging buffer copies into the stored code on the same edge, and `stage_cnt` clears.
  - Clears results, `end_sleep` and the timer, and clears the entry buffer, `entry_cnt` and `overrun`.
  - A partial store (fewer than CODE_LEN digits) never alters the stored code. The next store event continues the same staging.
- Compare event:
  - Match = `entry_cnt`==CODE_LEN && !`overrun` && entry==stored code.
  - On match, `correct_password` is set; otherwise `invalid_password` is set. Exactly one is high.
  - The entry buffer, `entry_cnt`, `overrun` and `stage_cnt` clear on the same edge.
- Results are held until the next input or store event, or reset. The FSM may sample them any number of cycles later.
- Lockout timer states:
  - IDLE: the timer idles until a compare event produces an invalid result.
  - COUNT: entered on that edge. The counter loads SLEEP_CYCLES−1 and decrements each cycle.
  - EXPIRED: reached when the counter hits 0. `end_sleep` goes high and holds; the timer returns to IDLE on an input or store event, or reset.
- A compare producing a correct result while in COUNT returns the timer to IDLE with `end_sleep`=0.
- A new invalid compare while in COUNT or EXPIRED restarts COUNT and deasserts `end_sleep`.

## Timing
- Reset values: all outputs 0, stored code = DEFAULT_CODE, all buffers, counters and flags 0, timer IDLE.
- Reset mid-operation aborts any partial entry, staging or countdown immediately.
- Capture latency: 1 cycle. Results are visible the cycle after the edge where `compare` rose.
- `end_sleep` rises exactly SLEEP_CYCLES cycles after the edge where `invalid_password` rose.
- SLEEP_CYCLES ≥4 guarantees the FSM reaches its sleep state before expiry.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `PASSCODE_MASTER_CODE_EN` defined: a compare also matches when `entry_cnt`==CODE_LEN && !`overrun` && entry==MASTER_CODE. The MASTER_CODE match cannot be changed by store events.
- `PASSCODE_MASTER_CODE_EN` undefined: only the stored code matches. MASTER_CODE is ignored and no comparator for it is built.

## Test plan
Defaults as listed under Interface.
- Default code: reset; input events 1,2,3,4; compare → `correct_password`=1 next cycle, `invalid_password`=0, `end_sleep` stays 0.
- Wrong code and lockout: inputs 1,2,3,5; compare → `invalid_password`=1; `end_sleep` rises exactly 8 cycles later and holds; next input event clears all three.
- New code: store events 9,8,7,6 → stored code 16'h9876; inputs 1,2,3,4 + compare → invalid; inputs 9,8,7,6 + compare → correct.
- Short/overrun entries:
  - Inputs 1,2,3 + compare → invalid.
  - Inputs 9,1,2,3,4 + compare → invalid (overrun).
  - Holding `input_value` high for 5 cycles captures one digit only.
- Reset mid-operation: store events 5,5; assert `system_reset` → stored code 16'h1234 and outputs 0. Invalid compare then reset at countdown cycle 4 → `end_sleep` never rises.
- Master code: with `PASSCODE_MASTER_CODE_EN` and MASTER_CODE 16'hABCD, inputs A,B,C,D + compare → correct. Without the macro → invalid.

Source files
------------

// File: rtl/passcode_checker.sv
// -----------------------------------------------------------------------------
// passcode_checker
//
// Passcode storage, comparison and lockout timer for the lock controller.
// The controller FSM drives three level signals (input_value, store_value,
// compare). Each rising edge of one of them is a single event. The keypad
// digit on digit_in is captured on input and store events.
//
//   input_value  : rising edge shifts digit_in into the attempt buffer
//   store_value  : rising edge shifts digit_in into the new-code staging
//                  buffer. CODE_LEN store events commit a new stored code.
//   compare      : rising edge evaluates the attempt and latches the result
//
// If several events occur in one cycle, compare wins over input, and input
// wins over store. The losing events are dropped.
//
// Ports:
//   clk              in   1        clock
//   system_reset     in   1        asynchronous, active-high reset
//   digit_in         in   DIGIT_W  keypad digit
//   input_value      in   1        FSM level: attempt digit capture
//   store_value      in   1        FSM level: new-code digit capture
//   compare          in   1        FSM level: evaluate attempt
//   correct_password out  1        held result: attempt matched
//   invalid_password out  1        held result: attempt rejected
//   end_sleep        out  1        held: lockout period has expired
//
// Build option:
//   PASSCODE_MASTER_CODE_EN  when defined, an attempt equal to MASTER_CODE is
//                            also accepted. Store events cannot change this
//                            code.
// -----------------------------------------------------------------------------
module passcode_checker #(
  parameter int                           DIGIT_W      = 4,
  parameter int                           CODE_LEN     = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]  DEFAULT_CODE = 16'h1234,
  parameter int                           SLEEP_CYCLES = 8,
  parameter logic [CODE_LEN*DIGIT_W-1:0]  MASTER_CODE  = 16'h0000
) (
  input  logic               clk,
  input  logic               system_reset,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               input_value,
  input  logic               store_value,
  input  logic               compare,
  output logic               correct_password,
  output logic               invalid_password,
  output logic               end_sleep
);

  localparam int CODE_W  = CODE_LEN * DIGIT_W;
  localparam int CNT_W   = $clog2(CODE_LEN + 1);
  localparam int SLEEP_W = $clog2(SLEEP_CYCLES);

  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(CODE_LEN);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(CODE_LEN - 1);
  localparam logic [SLEEP_W-1:0] SLEEP_LOAD = SLEEP_W'(SLEEP_CYCLES - 1);

  // Lockout timer states.
  localparam logic [1:0] TIMER_IDLE    = 2'd0;
  localparam logic [1:0] TIMER_COUNT   = 2'd1;
  localparam logic [1:0] TIMER_EXPIRED = 2'd2;

  // ---------------------------------------------------------------------------
  // Edge detection on the FSM levels
  // ---------------------------------------------------------------------------
  logic input_value_q;
  logic store_value_q;
  logic compare_q;

  // NOTE: every clocked register below is assigned with <= so that all
  // registers sample the pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk or posedge system_reset) begin
    if (system_reset) begin
      input_value_q <= 1'b0;
      store_value_q <= 1'b0;
      compare_q     <= 1'b0;
    end else begin
      input_value_q <= input_value;
      store_value_q <= store_value;
      compare_q     <= compare;
    end
  end

  // The priority masking makes at most one event active in any cycle.
  logic compare_event;
  logic input_event;
  logic store_event;

  assign compare_event = compare & ~compare_q;
  assign input_event   = input_value & ~input_value_q & ~compare_event;
  assign store_event   = store_value & ~store_value_q & ~compare_event
                         & ~input_event;

  // ---------------------------------------------------------------------------
  // Attempt entry buffer
  // ---------------------------------------------------------------------------
  // The newest digit enters at the LSB end, so after CODE_LEN digits the
  // first digit sits in the MSBs, in the same layout as the stored code.
  // Once the buffer is full, further digits push the oldest one out and set
  // overrun. A long attempt whose last CODE_LEN digits are correct is still
  // rejected.
  logic [CODE_W-1:0] entry_buf;
  logic [CNT_W-1:0]  entry_cnt;
  logic              overrun;
  logic [CODE_W-1:0] entry_shifted;

  assign entry_shifted = (entry_buf << DIGIT_W) | CODE_W'(digit_in);

  always_ff @(posedge clk or posedge system_reset) begin
    if (system_reset) begin
      entry_buf <= '0;
      entry_cnt <= '0;
      overrun   <= 1'b0;
    end else if (compare_event || store_event) begin
      // Every evaluation or re-programming starts a fresh attempt.
      entry_buf <= '0;
      entry_cnt <= '0;
      overrun   <= 1'b0;
    end else if (input_event) begin
      entry_buf <= entry_shifted;
      if (entry_cnt == CNT_FULL) begin
        overrun <= 1'b1;
      end else begin
        entry_cnt <= entry_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // New-code staging and stored code
  // ---------------------------------------------------------------------------
  // Digits collect in the staging buffer. The stored code changes only on the
  // edge that delivers the CODE_LEN-th digit, so a partial store never
  // disturbs it. Input events leave the staging count alone, which lets a
  // later store event continue the same staging. A compare event restarts it.
  logic [CODE_W-1:0] stage_buf;
  logic [CNT_W-1:0]  stage_cnt;
  logic [CODE_W-1:0] stored_code;
  logic [CODE_W-1:0] stage_shifted;

  assign stage_shifted = (stage_buf << DIGIT_W) | CODE_W'(digit_in);

  always_ff @(posedge clk or posedge system_reset) begin
    if (system_reset) begin
      stage_buf   <= '0;
      stage_cnt   <= '0;
      stored_code <= DEFAULT_CODE;
    end else if (compare_event) begin
      stage_cnt <= '0;
    end else if (store_event) begin
      stage_buf <= stage_shifted;
      if (stage_cnt == CNT_LAST) begin
        stored_code <= stage_shifted;
        stage_cnt   <= '0;
      end else begin
        stage_cnt <= stage_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Match evaluation
  // ---------------------------------------------------------------------------
  logic code_match;

  // NOTE: code_match is assigned a default first. Otherwise the paths that do
  // not assign it would infer a latch.
  always_comb begin
    code_match = 1'b0;
    if (entry_cnt == CNT_FULL && !overrun) begin
      code_match = (entry_buf == stored_code);
`ifdef PASSCODE_MASTER_CODE_EN
      code_match = code_match || (entry_buf == MASTER_CODE);
`endif
    end
  end

`ifndef PASSCODE_MASTER_CODE_EN
  // With the override disabled, MASTER_CODE only feeds this constant tie-off.
  // No comparator is built for it.
  logic unused_master_code;
  assign unused_master_code = ^MASTER_CODE;
`endif

  // ---------------------------------------------------------------------------
  // Results and lockout timer
  // ---------------------------------------------------------------------------
  // The counter loads SLEEP_CYCLES-1 on the rejecting edge. It then counts
  // down once per cycle. The edge that finds it at zero raises end_sleep, so
  // end_sleep rises exactly SLEEP_CYCLES cycles after invalid_password.
  logic [1:0]         timer_state;
  logic [SLEEP_W-1:0] sleep_cnt;

  always_ff @(posedge clk or posedge system_reset) begin
    if (system_reset) begin
      correct_password <= 1'b0;
      invalid_password <= 1'b0;
      end_sleep        <= 1'b0;
      timer_state      <= TIMER_IDLE;
      sleep_cnt        <= '0;
    end else if (compare_event) begin
      correct_password <= code_match;
      invalid_password <= ~code_match;
      end_sleep        <= 1'b0;
      if (code_match) begin
        timer_state <= TIMER_IDLE;
        sleep_cnt   <= '0;
      end else begin
        // This covers both a first rejection and a rejection that restarts
        // an active or expired lockout.
        timer_state <= TIMER_COUNT;
        sleep_cnt   <= SLEEP_LOAD;
      end
    end else if (input_event || store_event) begin
      correct_password <= 1'b0;
      invalid_password <= 1'b0;
      end_sleep        <= 1'b0;
      timer_state      <= TIMER_IDLE;
      sleep_cnt        <= '0;
    end else begin
      case (timer_state)
        TIMER_IDLE: begin
          sleep_cnt <= '0;
        end
        TIMER_COUNT: begin
          if (sleep_cnt == '0) begin
            timer_state <= TIMER_EXPIRED;
            end_sleep   <= 1'b1;
          end else begin
            sleep_cnt <= sleep_cnt - SLEEP_W'(1);
          end
        end
        TIMER_EXPIRED: begin
          end_sleep <= 1'b1;
        end
        default: begin
          // The unused encoding falls back to IDLE.
          timer_state <= TIMER_IDLE;
          end_sleep   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_passcode_checker.sv
// -----------------------------------------------------------------------------
// tb_passcode_checker
//
// Directed and randomized stimulus for passcode_checker. A queue-based
// reference model tracks the stored code, the attempt, the staging digits and
// the remaining lockout time. Outputs are checked at every falling edge.
// -----------------------------------------------------------------------------
module tb_passcode_checker;

  localparam int          DIGIT_W      = 4;
  localparam int          CODE_LEN     = 4;
  localparam int          SLEEP_CYCLES = 8;
  localparam logic [15:0] DEFAULT_CODE = 16'h1234;
  localparam logic [15:0] MASTER_CODE  = 16'hABCD;

  logic               clk = 1'b0;
  logic               system_reset;
  logic [DIGIT_W-1:0] digit_in;
  logic               input_value;
  logic               store_value;
  logic               compare;
  logic               correct_password;
  logic               invalid_password;
  logic               end_sleep;

  always #5 clk = ~clk;

  passcode_checker #(
    .DIGIT_W      (DIGIT_W),
    .CODE_LEN     (CODE_LEN),
    .DEFAULT_CODE (DEFAULT_CODE),
    .SLEEP_CYCLES (SLEEP_CYCLES),
    .MASTER_CODE  (MASTER_CODE)
  ) dut (
    .clk              (clk),
    .system_reset     (system_reset),
    .digit_in         (digit_in),
    .input_value      (input_value),
    .store_value      (store_value),
    .compare          (compare),
    .correct_password (correct_password),
    .invalid_password (invalid_password),
    .end_sleep        (end_sleep)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model: codes are kept as queues of digits, oldest first.
  // ---------------------------------------------------------------------------
  logic [3:0] m_stored[$];
  logic [3:0] m_entry[$];
  logic [3:0] m_stage[$];
  bit         m_overrun;
  bit         m_prev_in, m_prev_st, m_prev_cmp;
  bit         m_counting;
  int         m_sleep_left;
  bit         e_correct, e_invalid, e_end;

  function automatic logic [3:0] code_digit(logic [15:0] code, int i);
    return code[(CODE_LEN - 1 - i) * DIGIT_W +: DIGIT_W];
  endfunction

  function automatic bit entry_equals_code(logic [15:0] code);
    if (m_entry.size() != CODE_LEN) return 1'b0;
    for (int i = 0; i < CODE_LEN; i++)
      if (m_entry[i] != code_digit(code, i)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit entry_equals_stored();
    if (m_entry.size() != CODE_LEN) return 1'b0;
    for (int i = 0; i < CODE_LEN; i++)
      if (m_entry[i] != m_stored[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_stored.delete();
    for (int i = 0; i < CODE_LEN; i++) m_stored.push_back(code_digit(DEFAULT_CODE, i));
    m_entry.delete();
    m_stage.delete();
    m_overrun    = 1'b0;
    m_prev_in    = 1'b0;
    m_prev_st    = 1'b0;
    m_prev_cmp   = 1'b0;
    m_counting   = 1'b0;
    m_sleep_left = 0;
    e_correct    = 1'b0;
    e_invalid    = 1'b0;
    e_end        = 1'b0;
  endfunction

  // Apply one clock edge with the given levels to the model.
  function automatic void model_edge(bit iv, bit sv, bit cv, logic [3:0] d);
    bit ev_c, ev_i, ev_s, ok;
    ev_c = cv && !m_prev_cmp;
    ev_i = iv && !m_prev_in && !ev_c;
    ev_s = sv && !m_prev_st && !ev_c && !ev_i;
    m_prev_in  = iv;
    m_prev_st  = sv;
    m_prev_cmp = cv;
    if (ev_c) begin
      ok = !m_overrun && entry_equals_stored();
`ifdef PASSCODE_MASTER_CODE_EN
      ok = ok || (!m_overrun && entry_equals_code(MASTER_CODE));
`endif
      e_correct    = ok;
      e_invalid    = !ok;
      e_end        = 1'b0;
      m_counting   = !ok;
      m_sleep_left = SLEEP_CYCLES;
      m_entry.delete();
      m_overrun = 1'b0;
      m_stage.delete();
    end else if (ev_i) begin
      m_entry.push_back(d);
      if (m_entry.size() > CODE_LEN) begin
        void'(m_entry.pop_front());
        m_overrun = 1'b1;
      end
      e_correct  = 1'b0;
      e_invalid  = 1'b0;
      e_end      = 1'b0;
      m_counting = 1'b0;
    end else if (ev_s) begin
      m_stage.push_back(d);
      if (m_stage.size() == CODE_LEN) begin
        m_stored = m_stage;
        m_stage.delete();
      end
      e_correct  = 1'b0;
      e_invalid  = 1'b0;
      e_end      = 1'b0;
      m_counting = 1'b0;
      m_entry.delete();
      m_overrun = 1'b0;
    end else if (m_counting) begin
      m_sleep_left--;
      if (m_sleep_left == 0) begin
        e_end      = 1'b1;
        m_counting = 1'b0;
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Checking and stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".correct"}, correct_password, e_correct);
    check({tag, ".invalid"}, invalid_password, e_invalid);
    check({tag, ".end_sleep"}, end_sleep, e_end);
  endtask

  // Called just after a falling edge. Drives levels, takes one rising edge,
  // and checks at the following falling edge.
  task automatic step(input bit iv, input bit sv, input bit cv,
                      input logic [3:0] d, input string tag);
    input_value = iv;
    store_value = sv;
    compare     = cv;
    digit_in    = d;
    @(posedge clk);
    model_edge(iv, sv, cv, d);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, tag);
  endtask

  task automatic press_input(input logic [3:0] d);
    step(1'b1, 1'b0, 1'b0, d, "input");
    step(1'b0, 1'b0, 1'b0, d, "input_rel");
  endtask

  task automatic press_store(input logic [3:0] d);
    step(1'b0, 1'b1, 1'b0, d, "store");
    step(1'b0, 1'b0, 1'b0, d, "store_rel");
  endtask

  task automatic press_compare();
    step(1'b0, 1'b0, 1'b1, 4'h0, "compare");
    step(1'b0, 1'b0, 1'b0, 4'h0, "compare_rel");
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < CODE_LEN; i++) press_input(code_digit(code, i));
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset(input string tag);
    #2;
    system_reset = 1'b1;
    input_value  = 1'b0;
    store_value  = 1'b0;
    compare      = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    system_reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0] code_copy[$];
    int         r;

    system_reset = 1'b1;
    input_value  = 1'b0;
    store_value  = 1'b0;
    compare      = 1'b0;
    digit_in     = 4'h0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    system_reset = 1'b0;

    // Default code is accepted and no lockout follows.
    enter_code(16'h1234);
    press_compare();
    check("dflt.correct", correct_password, 1'b1);
    check("dflt.invalid", invalid_password, 1'b0);
    idle(10, "dflt_hold");
    check("dflt.no_sleep", end_sleep, 1'b0);

    // A wrong code is rejected. end_sleep rises 8 cycles after the result.
    enter_code(16'h1235);
    press_compare();
    check("wrong.invalid", invalid_password, 1'b1);
    idle(6, "lock_count");
    check("lock.early", end_sleep, 1'b0);
    idle(1, "lock_expire");
    check("lock.expired", end_sleep, 1'b1);
    idle(3, "lock_hold");
    check("lock.held", end_sleep, 1'b1);
    press_input(4'h1);
    check("clear.correct", correct_password, 1'b0);
    check("clear.invalid", invalid_password, 1'b0);
    check("clear.end_sleep", end_sleep, 1'b0);
    press_compare();

    // Program a new code.
    for (int i = 0; i < CODE_LEN; i++) press_store(code_digit(16'h9876, i));
    enter_code(16'h1234);
    press_compare();
    check("newcode.old_rejected", invalid_password, 1'b1);
    enter_code(16'h9876);
    press_compare();
    check("newcode.accepted", correct_password, 1'b1);

    // A reset during a partial store restores the default code.
    press_store(4'h5);
    press_store(4'h5);
    do_reset("reset_mid_store");
    enter_code(16'h1234);
    press_compare();
    check("reset.default_code", correct_password, 1'b1);

    // Short attempt and overrun attempt.
    enter_code(16'h1230 >> 0);
    for (int i = 0; i < 0; i++) press_input(4'h0);
    press_compare();
    press_input(4'h1);
    press_input(4'h2);
    press_input(4'h3);
    press_compare();
    check("short.invalid", invalid_password, 1'b1);
    press_input(4'h9);
    enter_code(16'h1234);
    press_compare();
    check("overrun.invalid", invalid_password, 1'b1);

    // A level held high for 5 cycles captures a single digit.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 4'h1, "held_input");
    step(1'b0, 1'b0, 1'b0, 4'h0, "held_rel");
    press_input(4'h2);
    press_input(4'h3);
    press_input(4'h4);
    press_compare();
    check("held.one_digit", correct_password, 1'b1);

    // A reset during the countdown prevents the expiry.
    enter_code(16'h1235);
    press_compare();
    idle(2, "abort_count");
    do_reset("reset_mid_count");
    idle(12, "after_abort");
    check("abort.no_sleep", end_sleep, 1'b0);

    // Override code.
    enter_code(MASTER_CODE);
    press_compare();
`ifdef PASSCODE_MASTER_CODE_EN
    check("master.accepted", correct_password, 1'b1);
`else
    check("master.rejected", invalid_password, 1'b1);
`endif

    // Randomized traffic checked against the model.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 10) begin
        code_copy = m_stored;
        for (int i = 0; i < CODE_LEN; i++) press_input(code_copy[i]);
        press_compare();
      end else if (r < 12) begin
        do_reset("rand_reset");
      end else begin
        step(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)), "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
